// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle for stream_mux_rr; in_last/out_last exist only with STREAM_MUX_LOCK_EN
interface stream_mux_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) ();
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      grant;
`ifdef STREAM_MUX_LOCK_EN
  logic [N-1:0]         in_last;
  logic                 out_last;

  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, grant, out_last
  );
  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, grant, out_last
  );
`else
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant
  );
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, grant
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux, round-robin or fixed select
// Packet lock to the current source channel is compiled in with STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] win;
  logic            has_win;
  logic            load;
`ifdef STREAM_MUX_LOCK_EN
  logic            locked;
`endif

  assign load = !bus.out_valid || bus.out_ready;

  always_comb begin
    has_win = 1'b0;
    win     = '0;
`ifdef STREAM_MUX_LOCK_EN
    // grant always holds the locked channel, since the lock is taken on its transfer
    if (locked) begin
      win     = bus.grant;
      has_win = bus.in_valid[bus.grant];
    end else
`endif
    if (bus.mode) begin
      win = bus.sel;
      if (int'(bus.sel) < N) has_win = bus.in_valid[bus.sel];
    end else begin
      // scan from lowest priority to highest so the nearest valid channel after rr_ptr wins
      for (int k = N; k >= 1; k--) begin
        if (bus.in_valid[(int'(rr_ptr) + k) % N]) begin
          has_win = 1'b1;
          win     = SELW'((int'(rr_ptr) + k) % N);
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && has_win) bus.in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.grant     <= '0;
      rr_ptr        <= SELW'(N - 1);
`ifdef STREAM_MUX_LOCK_EN
      bus.out_last  <= 1'b0;
      locked        <= 1'b0;
`endif
    end else if (load) begin
      bus.out_valid <= has_win;
      if (has_win) begin
        bus.out_data <= bus.in_data[int'(win) * WIDTH +: WIDTH];
        bus.grant    <= win;
        rr_ptr       <= win;
`ifdef STREAM_MUX_LOCK_EN
        bus.out_last <= bus.in_last[win];
        locked       <= !bus.in_last[win];
`endif
      end
    end
  end
endmodule
